// File: rtl/alu_wide_seq.sv
// Sequences a 2N-bit add/subtract through a shared N-bit ALU: low word, high word,
// and an optional +/-1 fix-up pass on the high word to propagate the low-word carry.
module alu_wide_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_op,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [3:0]     alu_ctrl,
    input  logic [N-1:0]   alu_result,
    input  logic [3:0]     alu_flags,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_result,
    output logic [3:0]     rsp_flags
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] CTRL_ADD = 4'b0000;
    localparam logic [3:0] CTRL_SUB = 4'b0001;

    state_t         state_q, state_d;
    logic           op_q, op_d;
    logic [2*N-1:0] a_q, a_d;
    logic [2*N-1:0] b_q, b_d;
    logic [N-1:0]   r_lo_q, r_lo_d;
    logic [N-1:0]   r_hi_q, r_hi_d;
    logic           c_lo_q, c_lo_d;
    logic           c_hi_q, c_hi_d;
    logic           c_fix_q, c_fix_d;

    logic [3:0]     op_ctrl;
    logic           need_fix;
    logic           alu_carry;
    logic           unused_alu_flags;
    logic           flag_n;
    logic           flag_z;
    logic           flag_c;
    logic           flag_v;

    assign op_ctrl          = op_q ? CTRL_SUB : CTRL_ADD;
    assign alu_carry        = alu_flags[1];
    assign unused_alu_flags = ^{alu_flags[3:2], alu_flags[0]};

    // A low-word carry (add) or borrow (sub, carry=0) must be folded into the high word.
    assign need_fix = op_q ? ~c_lo_q : c_lo_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        r_lo_d    = r_lo_q;
        r_hi_d    = r_hi_q;
        c_lo_d    = c_lo_q;
        c_hi_d    = c_hi_q;
        c_fix_d   = c_fix_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = CTRL_ADD;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = LO;
                end
            end
            LO: begin
                alu_a    = a_q[N-1:0];
                alu_b    = b_q[N-1:0];
                alu_ctrl = op_ctrl;
                r_lo_d   = alu_result;
                c_lo_d   = alu_carry;
                state_d  = HI;
            end
            HI: begin
                alu_a    = a_q[2*N-1:N];
                alu_b    = b_q[2*N-1:N];
                alu_ctrl = op_ctrl;
                r_hi_d   = alu_result;
                c_hi_d   = alu_carry;
                // Neutral value so the final carry reduces to c_hi when FIX is skipped.
                c_fix_d  = op_q;
                state_d  = need_fix ? FIX : DONE;
            end
            FIX: begin
                alu_a    = r_hi_q;
                alu_b    = N'(1);
                alu_ctrl = op_ctrl;
                r_hi_d   = alu_result;
                c_fix_d  = alu_carry;
                state_d  = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        flag_n = r_hi_q[N-1];
        flag_z = (r_lo_q == '0) && (r_hi_q == '0);
        flag_c = op_q ? (c_hi_q & c_fix_q) : (c_hi_q | c_fix_q);
        if (op_q) begin
            flag_v = (a_q[2*N-1] != b_q[2*N-1]) && (flag_n != a_q[2*N-1]);
        end else begin
            flag_v = (a_q[2*N-1] == b_q[2*N-1]) && (flag_n != a_q[2*N-1]);
        end
    end

    assign rsp_result = {r_hi_q, r_lo_q};
    assign rsp_flags  = (state_q == DONE) ? {flag_n, flag_z, flag_c, flag_v} : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_lo_q  <= '0;
            r_hi_q  <= '0;
            c_lo_q  <= 1'b0;
            c_hi_q  <= 1'b0;
            c_fix_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_lo_q  <= r_lo_d;
            r_hi_q  <= r_hi_d;
            c_lo_q  <= c_lo_d;
            c_hi_q  <= c_hi_d;
            c_fix_q <= c_fix_d;
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: behavioural 32-bit ALU plus a 64-bit
// arithmetic reference model for results, flags and latency.
module tb_alu_wide_seq;

    localparam int N = 32;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_op;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [3:0]     alu_ctrl;
    logic [N-1:0]   alu_result;
    logic [3:0]     alu_flags;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_result;
    logic [3:0]     rsp_flags;

    int checks;
    int errors;

    alu_wide_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared N-bit ALU: add for ctrl 0000, subtract for 0001; carry=1 on sub means no borrow.
    always_comb begin
        logic [N:0] wide;
        logic       sub;
        sub = (alu_ctrl == 4'b0001);
        if (sub) begin
            wide = {1'b0, alu_a} - {1'b0, alu_b};
        end else begin
            wide = {1'b0, alu_a} + {1'b0, alu_b};
        end
        alu_result   = wide[N-1:0];
        alu_flags[3] = wide[N-1];
        alu_flags[2] = (wide[N-1:0] == '0);
        alu_flags[1] = sub ? (alu_a >= alu_b) : wide[N];
        alu_flags[0] = sub ? ((alu_a[N-1] != alu_b[N-1]) && (wide[N-1] != alu_a[N-1]))
                           : ((alu_a[N-1] == alu_b[N-1]) && (wide[N-1] != alu_a[N-1]));
    end

    task automatic ref_model(input logic op, input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] r, output logic [3:0] f, output int lat);
        logic [64:0] wide;
        logic        c;
        logic        v;
        if (!op) begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[63:0];
            c    = wide[64];
            v    = (a[63] == b[63]) && (r[63] != a[63]);
            lat  = (({1'b0, a[31:0]} + {1'b0, b[31:0]}) > 33'h0_FFFF_FFFF) ? 4 : 3;
        end else begin
            r   = a - b;
            c   = (a >= b);
            v   = (a[63] != b[63]) && (r[63] != a[63]);
            lat = (a[31:0] < b[31:0]) ? 4 : 3;
        end
        f = {r[63], (r == 64'd0), c, v};
    endtask

    // Caller is mid-cycle with the DUT idle; returns at the negedge where rsp_valid is seen.
    task automatic issue(input logic op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic [3:0] flg,
                         output int lat, output bit got);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        lat = 1;
        got = 1'b0;
        res = '0;
        flg = '0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (got) begin
            res = rsp_result;
            flg = rsp_flags;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 6;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_result !== 64'd0) begin errors++; $display("[TB] FAIL reset_rsp_result got %h want 0", rsp_result); end
        if (rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_flags got %b want 0000", rsp_flags); end
        if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_alu_ops got %h/%h want 0/0", alu_a, alu_b); end
        if (alu_ctrl !== 4'b0000) begin errors++; $display("[TB] FAIL reset_alu_ctrl got %b want 0000", alu_ctrl); end
    endtask

    task automatic test_directed();
        logic        t_op [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] t_a  [6] = '{64'h00000001_00000002, 64'h00000000_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                                  64'h7FFFFFFF_FFFFFFFF, 64'd10, 64'd1};
        logic [63:0] t_b  [6] = '{64'h00000003_00000004, 64'd1, 64'd1, 64'd1, 64'd10, 64'd10};
        logic [63:0] t_r  [6] = '{64'h00000004_00000006, 64'h00000001_00000000, 64'd0,
                                  64'h80000000_00000000, 64'd0, 64'hFFFFFFFF_FFFFFFF7};
        logic [3:0]  t_f  [6] = '{4'b0000, 4'b0000, 4'b0110, 4'b1001, 4'b0110, 4'b1000};
        int          t_l  [6] = '{3, 4, 4, 4, 3, 4};
        logic [63:0] res;
        logic [3:0]  flg;
        int          lat;
        bit          got;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i], res, flg, lat, got);
            checks += 1;
            if (!got) begin
                errors++;
                $display("[TB] FAIL directed_%0d_timeout got no rsp_valid want rsp_valid", i);
            end else begin
                checks += 3;
                if (res !== t_r[i]) begin errors++; $display("[TB] FAIL directed_%0d_result got %h want %h", i, res, t_r[i]); end
                if (flg !== t_f[i]) begin errors++; $display("[TB] FAIL directed_%0d_flags got %b want %b", i, flg, t_f[i]); end
                if (lat != t_l[i]) begin errors++; $display("[TB] FAIL directed_%0d_latency got %0d want %0d", i, lat, t_l[i]); end
                finish_rsp();
            end
        end
    endtask

    task automatic test_random();
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [63:0] exp_r;
        logic [3:0]  flg;
        logic [3:0]  exp_f;
        int          lat;
        int          exp_l;
        bit          got;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: b[63:32] = a[63:32];
                2: a[31:0]  = 32'hFFFF_FFFF;
                default: b = a;
            endcase
            ref_model(op, a, b, exp_r, exp_f, exp_l);
            issue(op, a, b, res, flg, lat, got);
            checks += 1;
            if (!got) begin
                errors++;
                $display("[TB] FAIL random_%0d_timeout got no rsp_valid want rsp_valid", i);
            end else begin
                checks += 3;
                if (res !== exp_r) begin errors++; $display("[TB] FAIL random_%0d_result op=%b a=%h b=%h got %h want %h", i, op, a, b, res, exp_r); end
                if (flg !== exp_f) begin errors++; $display("[TB] FAIL random_%0d_flags op=%b a=%h b=%h got %b want %b", i, op, a, b, flg, exp_f); end
                if (lat != exp_l) begin errors++; $display("[TB] FAIL random_%0d_latency got %0d want %0d", i, lat, exp_l); end
                finish_rsp();
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] res;
        logic [63:0] res2;
        logic [3:0]  flg;
        logic [3:0]  flg2;
        int          lat;
        bit          got;
        issue(1'b1, 64'd1, 64'd10, res, flg, lat, got);
        checks += 1;
        if (!got) begin
            errors++;
            $display("[TB] FAIL hold_timeout got no rsp_valid want rsp_valid");
            return;
        end
        repeat (5) begin
            @(negedge clk);
            checks += 5;
            if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_rsp_valid got %b want 1", rsp_valid); end
            if (rsp_result !== 64'hFFFFFFFF_FFFFFFF7) begin errors++; $display("[TB] FAIL hold_result got %h want fffffffffffffff7", rsp_result); end
            if (rsp_flags !== 4'b1000) begin errors++; $display("[TB] FAIL hold_flags got %b want 1000", rsp_flags); end
            if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_ready got %b want 0", req_ready); end
            if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL hold_alu_idle got %h/%h/%b want 0/0/0000", alu_a, alu_b, alu_ctrl);
            end
        end
        finish_rsp();
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_req_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_rsp_valid got %b want 0", rsp_valid); end
        issue(1'b0, 64'h12345678_9ABCDEF0, 64'h00000001_00000001, res2, flg2, lat, got);
        checks += 1;
        if (!got || res2 !== 64'h12345679_9ABCDEF1 || flg2 !== 4'b0000 || lat != 3) begin
            errors++;
            $display("[TB] FAIL back_to_back got %h/%b/lat%0d want 123456799abcdef1/0000/lat3", res2, flg2, lat);
        end
        if (got) finish_rsp();
    endtask

    task automatic test_abort();
        bit seen;
        req_op    = 1'b1;
        req_a     = 64'd5;
        req_b     = 64'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks += 1;
        if (alu_ctrl !== 4'b0001) begin errors++; $display("[TB] FAIL abort_in_hi_ctrl got %b want 0001", alu_ctrl); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rsp_valid got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_req_ready got %b want 1", req_ready); end
        if (alu_ctrl !== 4'b0000) begin errors++; $display("[TB] FAIL abort_alu_ctrl got %b want 0000", alu_ctrl); end
        if (rsp_result !== 64'd0) begin errors++; $display("[TB] FAIL abort_result got %h want 0", rsp_result); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks += 1;
        if (seen) begin errors++; $display("[TB] FAIL abort_no_response got rsp_valid=1 want never"); end
        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_a     = 64'd3;
        req_b     = 64'd7;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        checks += 1;
        if (req_ready !== 1'b1 || alu_ctrl !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rst_beats_req got ready=%b ctrl=%b want ready=1 ctrl=0000", req_ready, alu_ctrl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Sequencer that performs 2N-bit add/subtract by driving the shared N-bit ALU over two or three passes: low word, high word, and a carry/borrow fix-up pass when needed. It sits between the execute-stage control and the ALU. It owns the ALU operand/ctrl inputs while busy, consumes the ALU result and flags, and returns a 2N-bit result with 64-bit-correct {N,Z,C,V} flags over valid/ready handshakes.

## Interface
- N, 32, ALU word width; the block operates on 2N-bit operands
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; equals (state==IDLE)
- req_op  in  1  operation select: 0 = add, 1 = subtract (a − b)
- req_a, req_b  in  2N  operands
- alu_a, alu_b  out  N  ALU operands
- alu_ctrl  out  4  ALU operation: 4'b0000 add, 4'b0001 sub
- alu_result  in  N  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_flags  in  4  {neg, zero, carry, overflow}; on subtract, carry=1 means no borrow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  2N  final result
- rsp_flags  out  4  {N, Z, C, V} of the 2N-bit operation

## Operation
- States: IDLE, LO, HI, FIX, DONE.
- IDLE
  - req_ready=1.
  - On req_valid: latch op, a, b; go to LO.
  - Operands are sampled only at the accept edge; later changes on req_* have no effect.
- LO
  - Drive alu_a=a[N-1:0], alu_b=b[N-1:0], alu_ctrl=op.
  - At the edge: capture r_lo=alu_result and c_lo=alu_flags[1]; go to HI.
- HI
  - Drive the high words with the same ctrl.
  - At the edge: capture r_hi and c_hi.
  - Fix-up is needed for add when c_lo=1, and for sub when c_lo=0.
  - If needed go to FIX, else go to DONE.
- FIX
  - Drive alu_a=r_hi, alu_b=1, alu_ctrl=op.
  - At the edge: r_hi←alu_result, c_fix←alu_flags[1]; go to DONE.
- Final flags
  - N = r_hi[N-1].
  - Z = (r_lo==0)&&(r_hi==0), computed from the registered words, not from ALU zero.
  - C for add: c_hi | c_fix. C for sub: c_hi & c_fix. When FIX was skipped, C = c_hi.
  - V for add: (a[2N-1]==b[2N-1]) && (N!=a[2N-1]).
  - V for sub: (a[2N-1]!=b[2N-1]) && (N!=a[2N-1]).
- DONE
  - rsp_valid=1; rsp_result={r_hi,r_lo} and rsp_flags stay stable.
  - On rsp_ready, return to IDLE.
- Whenever the state is IDLE or DONE, the ALU outputs are driven to zero (alu_a=0, alu_b=0, alu_ctrl=0000).

## Timing
- Reset values
  - State IDLE, so req_ready=1.
  - rsp_valid=0, rsp_result=0, rsp_flags=0.
  - alu_a=0, alu_b=0, alu_ctrl=0000.
  - All internal registers are cleared.
- Latency
  - The accept edge is edge 0.
  - rsp_valid rises in cycle 3 without fix-up, and in cycle 4 with fix-up.
- Each ALU pass occupies exactly one cycle. The ALU path is combinational within that cycle.
- req_ready is 0 in LO, HI, FIX and DONE. No request is accepted while a response is pending.
- Back-to-back operation:
  - The response handshake in DONE moves the block to IDLE.
  - The earliest next accept is the following edge, so throughput is one op per 4–5 cycles.
- rsp_ready held low: the block stays in DONE indefinitely with its outputs unchanged.
- rst during any state: the operation is abandoned and no response is produced. The cycle after reset shows the reset values.
- rst and req_valid in the same cycle: rst wins and the request is not accepted.

## Test plan
- add 0x00000001_00000002 + 0x00000003_00000004 → 0x00000004_00000006; flags 0000; no FIX; rsp_valid 3 cycles after accept.
- add 0x00000000_FFFFFFFF + 1 → 0x00000001_00000000; flags 0000; FIX used; latency 4.
- add 0xFFFFFFFF_FFFFFFFF + 1 → 0; Z=1, C=1, N=0, V=0; add 0x7FFFFFFF_FFFFFFFF + 1 → 0x80000000_00000000, N=1, V=1, C=0.
- sub 10 − 10 → 0; Z=1, C=1 (no borrow); latency 3. sub 1 − 10 → 0xFFFFFFFF_FFFFFFF7; N=1, C=0, V=0; latency 4.
- Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_result and rsp_flags stable, req_ready=0, ALU outputs zero. Release → IDLE next cycle, and a new request is accepted on the following edge.
- Assert rst during HI of a sub → next cycle rsp_valid=0, req_ready=1, alu_ctrl=0000; no response is ever emitted for the aborted op.
